// File: rtl/control_unit.sv
// control_unit: multi-cycle sequencer that fetches, decodes and steps each instruction
// through ALU, register-file and data-RAM handshakes using a seven-state Moore FSM.
module control_unit #(
    parameter int unsigned OPCODE_WIDTH = 5,
    parameter int unsigned FIELD_WIDTH  = 9,
    parameter int unsigned PC_WIDTH     = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [31:0]             instr,
    input  logic [3:0]              alu_flags,
    input  logic                    mem_ack,
    output logic [PC_WIDTH-1:0]     pc_out,
    output logic                    alu_en,
    output logic [OPCODE_WIDTH-1:0] alu_op,
    output logic [FIELD_WIDTH-1:0]  rs1_addr,
    output logic [FIELD_WIDTH-1:0]  rs2_addr,
    output logic                    rf_we,
    output logic [FIELD_WIDTH-1:0]  rf_waddr,
    output logic [1:0]              wb_sel,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [FIELD_WIDTH-1:0]  mem_addr,
    output logic [3:0]              flags_q,
    output logic                    halted,
    output logic                    illegal
);

    localparam int unsigned DST_LSB  = OPCODE_WIDTH;
    localparam int unsigned SRC1_LSB = DST_LSB + FIELD_WIDTH;
    localparam int unsigned SRC2_LSB = SRC1_LSB + FIELD_WIDTH;
    localparam int unsigned Z_BIT    = 2;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_RS1 = 2'b10;

    localparam logic [OPCODE_WIDTH-1:0] OP_ALU_LO = OPCODE_WIDTH'(1);
    localparam logic [OPCODE_WIDTH-1:0] OP_ALU_HI = OPCODE_WIDTH'(17);
    localparam logic [OPCODE_WIDTH-1:0] OP_CMP    = OPCODE_WIDTH'(18);
    localparam logic [OPCODE_WIDTH-1:0] OP_LOADI  = OPCODE_WIDTH'(20);
    localparam logic [OPCODE_WIDTH-1:0] OP_STORE  = OPCODE_WIDTH'(21);
    localparam logic [OPCODE_WIDTH-1:0] OP_MOV    = OPCODE_WIDTH'(22);
    localparam logic [OPCODE_WIDTH-1:0] OP_J      = OPCODE_WIDTH'(23);
    localparam logic [OPCODE_WIDTH-1:0] OP_BEQ    = OPCODE_WIDTH'(24);
    localparam logic [OPCODE_WIDTH-1:0] OP_HLT    = OPCODE_WIDTH'(25);

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_BR,
        ST_MEM,
        ST_WB,
        ST_HALT
    } state_e;

    state_e                  state_q, state_d;
    logic [31:0]             ir_q, ir_d;
    logic [PC_WIDTH-1:0]     pc_q, pc_d, pc_inc;
    logic [3:0]              flags_d;

    logic                    alu_en_q, alu_en_d;
    logic [OPCODE_WIDTH-1:0] alu_op_q, alu_op_d;
    logic [FIELD_WIDTH-1:0]  rs1_addr_q, rs1_addr_d;
    logic [FIELD_WIDTH-1:0]  rs2_addr_q, rs2_addr_d;
    logic                    rf_we_q, rf_we_d;
    logic [FIELD_WIDTH-1:0]  rf_waddr_q, rf_waddr_d;
    logic [1:0]              wb_sel_q, wb_sel_d;
    logic                    mem_req_q, mem_req_d;
    logic                    mem_we_q, mem_we_d;
    logic [FIELD_WIDTH-1:0]  mem_addr_q, mem_addr_d;
    logic                    halted_q, halted_d;

    logic [OPCODE_WIDTH-1:0] op_in, op_ir, op_nx;
    logic [FIELD_WIDTH-1:0]  dst_ir, dst_nx, src1_nx, src2_nx;

    assign op_in   = instr[OPCODE_WIDTH-1:0];
    assign op_ir   = ir_q[OPCODE_WIDTH-1:0];
    assign dst_ir  = ir_q[DST_LSB +: FIELD_WIDTH];
    assign op_nx   = ir_d[OPCODE_WIDTH-1:0];
    assign dst_nx  = ir_d[DST_LSB +: FIELD_WIDTH];
    assign src1_nx = ir_d[SRC1_LSB +: FIELD_WIDTH];
    assign src2_nx = ir_d[SRC2_LSB +: FIELD_WIDTH];
    assign pc_inc  = pc_q + PC_WIDTH'(1);

    function automatic logic is_alu(input logic [OPCODE_WIDTH-1:0] op);
        return (op >= OP_ALU_LO) && (op <= OP_ALU_HI);
    endfunction

    function automatic logic is_illegal(input logic [OPCODE_WIDTH-1:0] op);
        return (op == '0) || (op > OP_HLT);
    endfunction

    // Next state, architectural state updates, and the decode-time illegal pulse
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        pc_d    = pc_q;
        flags_d = flags_q;
        illegal = 1'b0;
        case (state_q)
            ST_FETCH: state_d = ST_DECODE;
            ST_DECODE: begin
                ir_d = instr;
                if (is_alu(op_in) || (op_in == OP_CMP) || (op_in == OP_BEQ)) begin
                    state_d = ST_EXEC;
                end else if ((op_in == OP_LOADI) || (op_in == OP_STORE)) begin
                    state_d = ST_MEM;
                end else if (op_in == OP_MOV) begin
                    state_d = ST_WB;
                end else if (op_in == OP_J) begin
                    state_d = ST_BR;
                end else if (op_in == OP_HLT) begin
                    state_d = ST_HALT;
                end else begin
                    // NOP and undefined opcodes both retire here
                    illegal = is_illegal(op_in);
                    state_d = ST_FETCH;
                    pc_d    = pc_inc;
                end
            end
            ST_EXEC: state_d = is_alu(op_ir) ? ST_WB : ST_BR;
            ST_BR: begin
                state_d = ST_FETCH;
                if (op_ir == OP_J) begin
                    pc_d = PC_WIDTH'(dst_ir);
                end else begin
                    flags_d = alu_flags;
                    pc_d    = ((op_ir == OP_BEQ) && alu_flags[Z_BIT]) ? PC_WIDTH'(dst_ir) : pc_inc;
                end
            end
            ST_MEM: begin
                if (mem_ack) begin
                    if (op_ir == OP_STORE) begin
                        state_d = ST_FETCH;
                        pc_d    = pc_inc;
                    end else begin
                        state_d = ST_WB;
                    end
                end
            end
            ST_WB: begin
                state_d = ST_FETCH;
                pc_d    = pc_inc;
                if (is_alu(op_ir)) begin
                    flags_d = alu_flags;
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_FETCH;
        endcase
    end

    // Moore output decode of the upcoming state/IR, registered below
    always_comb begin
        alu_en_d   = 1'b0;
        alu_op_d   = '0;
        rs1_addr_d = '0;
        rs2_addr_d = '0;
        rf_we_d    = 1'b0;
        rf_waddr_d = '0;
        wb_sel_d   = WB_ALU;
        mem_req_d  = 1'b0;
        mem_we_d   = 1'b0;
        mem_addr_d = '0;
        halted_d   = 1'b0;
        case (state_d)
            ST_EXEC: begin
                alu_en_d   = 1'b1;
                alu_op_d   = (op_nx == OP_BEQ) ? OP_CMP : op_nx;
                rs1_addr_d = src1_nx;
                rs2_addr_d = src2_nx;
            end
            ST_MEM: begin
                mem_req_d = 1'b1;
                if (op_nx == OP_STORE) begin
                    mem_we_d   = 1'b1;
                    mem_addr_d = dst_nx;
                    rs1_addr_d = src1_nx;
                end else begin
                    mem_addr_d = src1_nx;
                end
            end
            ST_WB: begin
                rf_we_d    = 1'b1;
                rf_waddr_d = dst_nx;
                if (op_nx == OP_MOV) begin
                    wb_sel_d   = WB_RS1;
                    rs1_addr_d = src1_nx;
                end else if (op_nx == OP_LOADI) begin
                    wb_sel_d = WB_MEM;
                end
            end
            ST_HALT: halted_d = 1'b1;
            default: halted_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_FETCH;
            ir_q       <= '0;
            pc_q       <= '0;
            flags_q    <= '0;
            alu_en_q   <= 1'b0;
            alu_op_q   <= '0;
            rs1_addr_q <= '0;
            rs2_addr_q <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            wb_sel_q   <= WB_ALU;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            pc_q       <= pc_d;
            flags_q    <= flags_d;
            alu_en_q   <= alu_en_d;
            alu_op_q   <= alu_op_d;
            rs1_addr_q <= rs1_addr_d;
            rs2_addr_q <= rs2_addr_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            wb_sel_q   <= wb_sel_d;
            mem_req_q  <= mem_req_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            halted_q   <= halted_d;
        end
    end

    assign pc_out   = pc_q;
    assign alu_en   = alu_en_q;
    assign alu_op   = alu_op_q;
    assign rs1_addr = rs1_addr_q;
    assign rs2_addr = rs2_addr_q;
    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign wb_sel   = wb_sel_q;
    assign mem_req  = mem_req_q;
    assign mem_we   = mem_we_q;
    assign mem_addr = mem_addr_q;
    assign halted   = halted_q;

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: instruction-level reference model producing a per-cycle expected
// trace, checked every cycle, plus hand-computed pins for each directed program.
module tb_control_unit;

    localparam int unsigned CYC_MAX = 256;

    typedef struct {
        logic [31:0] pc;
        logic        alu_en;
        logic [4:0]  alu_op;
        logic [8:0]  rs1;
        logic [8:0]  rs2;
        logic        rf_we;
        logic [8:0]  waddr;
        logic [1:0]  wb_sel;
        logic        mem_req;
        logic        mem_we;
        logic [8:0]  mem_addr;
        logic [3:0]  flags;
        logic        halted;
        logic        illegal;
    } obs_t;

    logic        clk       = 1'b0;
    logic        rst       = 1'b0;
    logic [31:0] instr;
    logic [3:0]  alu_flags = 4'h0;
    logic        mem_ack   = 1'b0;
    logic [31:0] pc_out;
    logic        alu_en;
    logic [4:0]  alu_op;
    logic [8:0]  rs1_addr;
    logic [8:0]  rs2_addr;
    logic        rf_we;
    logic [8:0]  rf_waddr;
    logic [1:0]  wb_sel;
    logic        mem_req;
    logic        mem_we;
    logic [8:0]  mem_addr;
    logic [3:0]  flags_q;
    logic        halted;
    logic        illegal;

    logic [31:0] prog [0:511];
    obs_t        exp_q [$];
    obs_t        tr [0:CYC_MAX-1];
    int unsigned cyc       = 0;
    bit          chk_en    = 1'b0;
    int unsigned n_checks  = 0;
    int unsigned n_errors  = 0;
    int unsigned ack_delay = 0;
    int unsigned mem_wait  = 0;
    bit          stray_ack = 1'b0;

    control_unit dut (
        .clk      (clk),
        .rst      (rst),
        .instr    (instr),
        .alu_flags(alu_flags),
        .mem_ack  (mem_ack),
        .pc_out   (pc_out),
        .alu_en   (alu_en),
        .alu_op   (alu_op),
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr),
        .rf_we    (rf_we),
        .rf_waddr (rf_waddr),
        .wb_sel   (wb_sel),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .flags_q  (flags_q),
        .halted   (halted),
        .illegal  (illegal)
    );

    always #5 clk = ~clk;

    assign instr = prog[pc_out[8:0]];

    function automatic logic [31:0] enc(input int unsigned op, input int unsigned d,
                                        input int unsigned s1, input int unsigned s2);
        return {9'(s2), 9'(s1), 9'(d), 5'(op)};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s (cycle %0d): actual 0x%0h, required 0x%0h", nm, cyc, act, exp);
        end
    endtask

    function automatic obs_t idle(input logic [31:0] pc, input logic [3:0] f);
        obs_t r;
        r = '{default: '0};
        r.pc    = pc;
        r.flags = f;
        return r;
    endfunction

    // Data RAM responder: acknowledges on the (ack_delay+1)-th requesting cycle
    always @(negedge clk) begin
        if (mem_req === 1'b1) begin
            mem_ack  = stray_ack || (mem_wait == ack_delay);
            mem_wait = mem_wait + 1;
        end else begin
            mem_ack  = stray_ack;
            mem_wait = 0;
        end
    end

    // Instruction-level model: expand each instruction into its cycle-by-cycle outputs
    task automatic build_model(input int unsigned n);
        obs_t        r;
        logic [31:0] pc;
        logic [3:0]  flg;
        bit          hlt;
        logic [31:0] ins;
        int unsigned op;
        int unsigned mem_cycles;
        logic [8:0]  d, s1, s2;
        exp_q.delete();
        pc  = 0;
        flg = 0;
        hlt = 0;
        mem_cycles = stray_ack ? 1 : ack_delay + 1;
        while (exp_q.size() < n) begin
            r = idle(pc, flg);
            if (hlt) begin
                r.halted = 1'b1;
                exp_q.push_back(r);
                continue;
            end
            ins = prog[pc[8:0]];
            op  = 32'(ins[4:0]);
            d   = ins[13:5];
            s1  = ins[22:14];
            s2  = ins[31:23];
            exp_q.push_back(r);
            r.illegal = (op == 0) || (op >= 26);
            exp_q.push_back(r);
            r.illegal = 1'b0;
            if ((op >= 1 && op <= 18) || op == 24) begin
                r.alu_en = 1'b1;
                r.alu_op = (op == 24) ? 5'd18 : 5'(op);
                r.rs1    = s1;
                r.rs2    = s2;
                exp_q.push_back(r);
                r = idle(pc, flg);
                if (op <= 17) begin
                    r.rf_we = 1'b1;
                    r.waddr = d;
                end
                exp_q.push_back(r);
                flg = alu_flags;
                pc  = (op == 24 && alu_flags[2]) ? 32'(d) : pc + 32'd1;
            end else if (op == 22) begin
                r.rf_we  = 1'b1;
                r.waddr  = d;
                r.wb_sel = 2'b10;
                r.rs1    = s1;
                exp_q.push_back(r);
                pc = pc + 32'd1;
            end else if (op == 20 || op == 21) begin
                for (int k = 0; k < int'(mem_cycles) && exp_q.size() < n; k++) begin
                    r = idle(pc, flg);
                    r.mem_req = 1'b1;
                    if (op == 21) begin
                        r.mem_we   = 1'b1;
                        r.mem_addr = d;
                        r.rs1      = s1;
                    end else begin
                        r.mem_addr = s1;
                    end
                    exp_q.push_back(r);
                end
                if (op == 20) begin
                    r = idle(pc, flg);
                    r.rf_we  = 1'b1;
                    r.waddr  = d;
                    r.wb_sel = 2'b01;
                    exp_q.push_back(r);
                end
                pc = pc + 32'd1;
            end else if (op == 23) begin
                exp_q.push_back(r);
                pc = 32'(d);
            end else if (op == 25) begin
                hlt = 1'b1;
            end else begin
                pc = pc + 32'd1;
            end
        end
        while (exp_q.size() > n) void'(exp_q.pop_back());
    endtask

    // Per-cycle compare of every output against the model trace
    always @(negedge clk) begin : cmp_p
        obs_t e;
        obs_t a;
        if (chk_en && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a.pc = pc_out;       a.alu_en = alu_en;     a.alu_op = alu_op;
            a.rs1 = rs1_addr;    a.rs2 = rs2_addr;      a.rf_we = rf_we;
            a.waddr = rf_waddr;  a.wb_sel = wb_sel;     a.mem_req = mem_req;
            a.mem_we = mem_we;   a.mem_addr = mem_addr; a.flags = flags_q;
            a.halted = halted;   a.illegal = illegal;
            cyc = cyc + 1;
            if (cyc < CYC_MAX) tr[cyc] = a;
            chk("pc_out", a.pc, e.pc);
            chk("alu_en", 32'(a.alu_en), 32'(e.alu_en));
            chk("alu_op", 32'(a.alu_op), 32'(e.alu_op));
            chk("rs1_addr", 32'(a.rs1), 32'(e.rs1));
            chk("rs2_addr", 32'(a.rs2), 32'(e.rs2));
            chk("rf_we", 32'(a.rf_we), 32'(e.rf_we));
            chk("rf_waddr", 32'(a.waddr), 32'(e.waddr));
            chk("wb_sel", 32'(a.wb_sel), 32'(e.wb_sel));
            chk("mem_req", 32'(a.mem_req), 32'(e.mem_req));
            chk("mem_we", 32'(a.mem_we), 32'(e.mem_we));
            chk("mem_addr", 32'(a.mem_addr), 32'(e.mem_addr));
            chk("flags_q", 32'(a.flags), 32'(e.flags));
            chk("halted", 32'(a.halted), 32'(e.halted));
            chk("illegal", 32'(a.illegal), 32'(e.illegal));
            chk("one_strobe", 32'((int'(a.alu_en) + int'(a.rf_we) + int'(a.mem_req)) > 1), 32'd0);
        end
    end

    task automatic clear_prog();
        for (int i = 0; i < 512; i++) prog[i] = enc(25, 0, 0, 0);
    endtask

    // Reset for one edge, then compare n cycles starting with the first fetch
    task automatic run_test(input int unsigned n);
        build_model(n);
        rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        cyc    = 0;
        chk_en = 1'b1;
        repeat (n) @(negedge clk);
        #1 chk_en = 1'b0;
        chk("model_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual still running, required finish");
        $fatal(1);
    end

    initial begin
        int unsigned n_ill;
        int unsigned n_strb;
        clear_prog();

        // ADDS dest 3, src1 1, src2 2
        prog[0]   = enc(6, 3, 1, 2);
        alu_flags = 4'b1010;
        run_test(8);
        chk("rst pc_out", tr[1].pc, 32'd0);
        chk("rst flags", 32'(tr[1].flags), 32'd0);
        chk("rst alu_en", 32'(tr[1].alu_en), 32'd0);
        chk("adds c3 alu_en", 32'(tr[3].alu_en), 32'd1);
        chk("adds c3 alu_op", 32'(tr[3].alu_op), 32'd6);
        chk("adds c3 rs1", 32'(tr[3].rs1), 32'd1);
        chk("adds c3 rs2", 32'(tr[3].rs2), 32'd2);
        chk("adds c4 rf_we", 32'(tr[4].rf_we), 32'd1);
        chk("adds c4 rf_waddr", 32'(tr[4].waddr), 32'd3);
        chk("adds c4 pc", tr[4].pc, 32'd0);
        chk("adds c5 pc", tr[5].pc, 32'd1);
        chk("adds c5 flags", 32'(tr[5].flags), 32'hA);

        // LOADI with ack on the fourth request cycle
        clear_prog();
        prog[0]   = enc(20, 7, 9'h55, 0);
        ack_delay = 3;
        run_test(10);
        for (int c = 3; c <= 6; c++) begin
            chk("loadi mem_req", 32'(tr[c].mem_req), 32'd1);
            chk("loadi mem_addr", 32'(tr[c].mem_addr), 32'h55);
        end
        chk("loadi c7 mem_req", 32'(tr[7].mem_req), 32'd0);
        chk("loadi c7 rf_we", 32'(tr[7].rf_we), 32'd1);
        chk("loadi c7 wb_sel", 32'(tr[7].wb_sel), 32'd1);
        chk("loadi c7 rf_waddr", 32'(tr[7].waddr), 32'd7);
        chk("loadi c8 pc", tr[8].pc, 32'd1);

        // BEQ taken and not taken
        clear_prog();
        ack_delay = 0;
        prog[0]   = enc(24, 9'h1F0, 4, 5);
        alu_flags = 4'b0100;
        run_test(8);
        chk("beq z1 alu_op", 32'(tr[3].alu_op), 32'd18);
        chk("beq z1 c4 pc", tr[4].pc, 32'd0);
        chk("beq z1 c5 pc", tr[5].pc, 32'h1F0);
        chk("beq z1 flags", 32'(tr[5].flags), 32'h4);
        alu_flags = 4'b1011;
        run_test(8);
        chk("beq z0 c5 pc", tr[5].pc, 32'd1);
        chk("beq z0 flags", 32'(tr[5].flags), 32'hB);

        // Undefined opcode 28
        clear_prog();
        prog[0] = enc(28, 1, 2, 3);
        run_test(6);
        n_ill  = 0;
        n_strb = 0;
        for (int c = 1; c <= 6; c++) n_ill += 32'(tr[c].illegal);
        for (int c = 1; c <= 2; c++) n_strb += 32'(tr[c].alu_en | tr[c].rf_we | tr[c].mem_req);
        chk("ill pulses", n_ill, 32'd1);
        chk("ill c2", 32'(tr[2].illegal), 32'd1);
        chk("ill strobes", n_strb, 32'd0);
        chk("ill c3 pc", tr[3].pc, 32'd1);

        // HLT at PC 5 after five NOPs, then reset releases it
        clear_prog();
        for (int i = 0; i < 5; i++) prog[i] = enc(19, 0, 0, 0);
        run_test(34);
        for (int c = 13; c <= 32; c++) begin
            chk("hlt halted", 32'(tr[c].halted), 32'd1);
            chk("hlt pc", tr[c].pc, 32'd5);
        end
        run_test(4);
        chk("hlt rst pc", tr[1].pc, 32'd0);
        chk("hlt rst halted", 32'(tr[1].halted), 32'd0);
        chk("nop c3 pc", tr[3].pc, 32'd1);

        // CMP, MOV, STORE, J, ADD with mem_ack held high throughout
        clear_prog();
        prog[0]   = enc(18, 0, 1, 2);
        prog[1]   = enc(22, 9, 4, 0);
        prog[2]   = enc(21, 9'h20, 3, 0);
        prog[3]   = enc(23, 8, 0, 0);
        prog[8]   = enc(1, 2, 6, 7);
        alu_flags = 4'b0011;
        stray_ack = 1'b1;
        run_test(24);
        chk("cmp c4 flags", 32'(tr[4].flags), 32'd0);
        chk("cmp c5 flags", 32'(tr[5].flags), 32'd3);
        chk("cmp c5 pc", tr[5].pc, 32'd1);
        chk("mov wb_sel", 32'(tr[7].wb_sel), 32'd2);
        chk("mov rs1", 32'(tr[7].rs1), 32'd4);
        chk("mov rf_waddr", 32'(tr[7].waddr), 32'd9);
        chk("mov c8 pc", tr[8].pc, 32'd2);
        chk("st mem_we", 32'(tr[10].mem_we), 32'd1);
        chk("st mem_addr", 32'(tr[10].mem_addr), 32'h20);
        chk("st rs1", 32'(tr[10].rs1), 32'd3);
        chk("st c11 mem_req", 32'(tr[11].mem_req), 32'd0);
        chk("st c11 pc", tr[11].pc, 32'd3);
        chk("j c14 pc", tr[14].pc, 32'd8);
        chk("add alu_op", 32'(tr[16].alu_op), 32'd1);
        chk("add rf_we", 32'(tr[17].rf_we), 32'd1);
        chk("end halted", 32'(tr[20].halted), 32'd1);
        chk("end pc", tr[20].pc, 32'd9);
        stray_ack = 1'b0;

        // Reset while STORE waits for an acknowledge that never comes
        clear_prog();
        prog[0]   = enc(21, 9'h40, 3, 0);
        ack_delay = 1000;
        run_test(5);
        chk("st wait mem_req", 32'(tr[5].mem_req), 32'd1);
        chk("st wait mem_addr", 32'(tr[5].mem_addr), 32'h40);
        run_test(6);
        chk("st rst mem_req", 32'(tr[1].mem_req), 32'd0);
        chk("st rst pc", tr[1].pc, 32'd0);
        chk("st rst c3 mem_req", 32'(tr[3].mem_req), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The block SHALL have parameter OPCODE_WIDTH, default 5, the opcode field width at instr[4:0].
REQ-002 The block SHALL have parameter FIELD_WIDTH, default 9, the width of each of dest instr[13:5], src1 instr[22:14] and src2 instr[31:23].
REQ-003 The block SHALL have parameter PC_WIDTH, default 32, the program counter width.
REQ-004 The block SHALL have port clk  input  1  the single clock; all state changes occur on its rising edge.
REQ-005 The block SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-006 The block SHALL have port instr  input  32  program-memory read data, valid one cycle after pc_out is presented.
REQ-007 The block SHALL have port alu_flags  input  4  {N,Z,C,V}, valid one cycle after alu_en.
REQ-008 The block SHALL have port mem_ack  input  1  data-RAM completion handshake.
REQ-009 The block SHALL have port pc_out  output  PC_WIDTH  program-memory address.
REQ-010 The block SHALL have port alu_en  output  1  ALU enable strobe.
REQ-011 The block SHALL have port alu_op  output  5  opcode forwarded to the ALU.
REQ-012 The block SHALL have ports rs1_addr and rs2_addr  output  FIELD_WIDTH each  register-file read addresses (src1, src2).
REQ-013 The block SHALL have ports rf_we (output, 1), rf_waddr (output, FIELD_WIDTH) and wb_sel (output, 2), where wb_sel is 00 ALU, 01 memory, 10 rs1 data.
REQ-014 The block SHALL have ports mem_req, mem_we (output, 1 each) and mem_addr (output, FIELD_WIDTH).
REQ-015 The block SHALL have ports flags_q (output, 4, latched flags), halted (output, 1) and illegal (output, 1, single-cycle pulse).

Function
REQ-016 The FSM SHALL have states FETCH, DECODE, EXEC, BR, MEM, WB and HALT.
REQ-017 FETCH SHALL present pc_out for one cycle and then go to DECODE; DECODE SHALL latch instr into an internal IR.
REQ-018 Opcode groups SHALL be: ALU 1-17; CMP 18; NOP 19; LOADI 20; STORE 21; MOV 22; J 23; BEQ 24; HLT 25.
REQ-019 Opcodes 0 and 26-31 SHALL pulse illegal for one cycle in DECODE and then execute as NOP.
REQ-020 For ALU ops the sequence SHALL be DECODE -> EXEC (alu_en=1, alu_op=opcode, one cycle) -> WB (rf_we=1, rf_waddr=dest, wb_sel=00, flags_q<=alu_flags) -> FETCH, i.e. 4 cycles per instruction.
REQ-021 CMP SHALL run DECODE -> EXEC -> BR, latch flags_q in BR, perform no write, and take 4 cycles.
REQ-022 NOP SHALL go DECODE -> FETCH and take 2 cycles.
REQ-023 MOV SHALL go DECODE -> WB with wb_sel=10, rf_waddr=dest and rs1_addr=src1, taking 3 cycles.
REQ-024 LOADI SHALL go DECODE -> MEM (mem_req=1, mem_we=0, mem_addr=src1), hold MEM until mem_ack=1, then go to WB (wb_sel=01, rf_waddr=dest).
REQ-025 STORE SHALL enter MEM with mem_req=1, mem_we=1, mem_addr=dest and rs1_addr=src1, hold MEM until mem_ack, then go to FETCH.
REQ-026 mem_req SHALL remain high every cycle in MEM; mem_ack outside MEM SHALL be ignored.
REQ-027 mem_ack high on the first MEM cycle SHALL complete that access in one cycle.
REQ-028 J SHALL set PC <= zero-extended dest and go to FETCH (3 cycles including FETCH).
REQ-029 BEQ SHALL issue alu_en with alu_op=18 (CMP) on src1/src2 in EXEC; in BR, if alu_flags Z=1, PC SHALL be set to zero-extended dest, else PC <= PC+1.
REQ-030 BEQ SHALL update flags_q.
REQ-031 All non-branching instructions SHALL increment PC by 1 on the edge leaving their last state; PC SHALL wrap from 2^PC_WIDTH-1 to 0.
REQ-032 HLT SHALL enter HALT: halted=1, all strobes 0, PC frozen at the HLT address; the FSM SHALL leave HALT only on reset.
REQ-033 alu_en, rf_we and mem_req SHALL never be asserted in the same cycle.
REQ-034 Outputs SHALL be Moore-decoded from state and IR only, except illegal.

Reset
REQ-035 When rst=0 at a rising edge, the block SHALL set: state=FETCH, PC=0, IR=0, flags_q=0, halted=0, illegal=0, alu_en=rf_we=mem_req=mem_we=0, wb_sel=00, alu_op=0, all addresses 0.
REQ-036 Reset SHALL take priority over every state, including MEM wait and HALT.
REQ-037 A pending memory access SHALL be abandoned with mem_req low in the cycle after the reset edge.
REQ-038 The first fetch after reset SHALL occur in the first cycle with rst=1.

Verification
REQ-039 Bench SHALL check ADDS (opcode 6, dest 3, src1 1, src2 2): alu_en in cycle 3, rf_we with rf_waddr=3 in cycle 4, pc_out 0->1.
REQ-040 Bench SHALL check LOADI with mem_ack delayed 3 cycles: mem_req high 4 cycles with mem_addr=src1, then WB wb_sel=01, total 7 cycles.
REQ-041 Bench SHALL check BEQ dest=0x1F0: with alu_flags Z=1, next pc_out=0x1F0; with Z=0, next pc_out=PC+1.
REQ-042 Bench SHALL check opcode 28: illegal pulses exactly once, no strobes, PC+1.
REQ-043 Bench SHALL check HLT at PC=5: halted=1 and pc_out=5 held for 20 cycles; rst=0 for one edge -> pc_out=0, halted=0.
REQ-044 Bench SHALL check rst=0 during STORE MEM wait: mem_req=0 the next cycle, state FETCH, PC=0.
